// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU data port and write-only loader
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cpu_mem_op,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        ld_req,
   input  logic [13:0] ld_addr,
   input  logic [31:0] ld_wdata,
   output logic        ld_ack,
   output logic [15:0] ld_count,
   output logic        ram_en,
   output logic        ram_we,
   output logic [13:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   // Shared MEM op codes; any other value behaves as NOP.
   localparam logic [2:0] MEM_NOP_OP = 3'd0;
   localparam logic [2:0] MEM_LW_OP  = 3'd1;
   localparam logic [2:0] MEM_SW_OP  = 3'd2;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_LD  = 1'b1;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic [15:0] count_q;

   logic        cpu_is_lw;
   logic        cpu_is_sw;
   logic        cpu_pend;
   logic        ld_pend;
   logic        grant_cpu;
   logic        grant_ld;
   logic        unused_addr_bits;

   // Only the word-select bits of the CPU byte address reach the RAM.
   assign unused_addr_bits = &{1'b0, cpu_addr[31:16], cpu_addr[1:0]};

   assign cpu_is_lw = (cpu_mem_op == MEM_LW_OP);
   assign cpu_is_sw = (cpu_mem_op == MEM_SW_OP);

   // Requests are only considered in IDLE; RD_WAIT owns the cycle for load return.
   assign cpu_pend  = !rst && (state == IDLE) && (cpu_is_lw || cpu_is_sw);
   assign ld_pend   = !rst && (state == IDLE) && ld_req;

   // On a tie the requester that lost last time wins.
   assign grant_cpu = cpu_pend && (!ld_pend || (last_grant == GRANT_LD));
   assign grant_ld  = ld_pend && (!cpu_pend || (last_grant == GRANT_CPU));

   // The counter register is still X before the first reset edge, so hide it during reset.
   assign ld_count  = rst ? 16'h0000 : count_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a granted load spends exactly one cycle waiting for RAM data.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_cpu && cpu_is_lw) state_next = RD_WAIT;
         RD_WAIT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: drive the RAM for the granted requester and stall an ungranted CPU.
   always_comb begin
      cpu_rdata = 32'h0;
      cpu_stall = 1'b0;
      ld_ack    = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 14'h0;
      ram_wdata = 32'h0;
      if (!rst) begin
         if (state == RD_WAIT) begin
            cpu_rdata = ram_rdata;
         end else begin
            if (grant_cpu) begin
               ram_en   = 1'b1;
               ram_addr = cpu_addr[15:2];
               if (cpu_is_sw) begin
                  ram_we    = 1'b1;
                  ram_wdata = cpu_wdata;
               end else begin
                  cpu_stall = 1'b1;
               end
            end
            if (grant_ld) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = ld_addr;
               ram_wdata = ld_wdata;
               ld_ack    = 1'b1;
            end
            if (cpu_pend && !grant_cpu) begin
               cpu_stall = 1'b1;
            end
         end
      end
   end

   // Remember who was granted so the next tie goes the other way.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_CPU;
      end else if (grant_ld) begin
         last_grant <= GRANT_LD;
      end else if (grant_cpu) begin
         last_grant <= GRANT_CPU;
      end
   end

   // Count accepted loader writes, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 16'h0000;
      end else if (grant_ld && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam logic [2:0] NOP = 3'd0;
   localparam logic [2:0] LW  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   localparam logic [31:0] DA = 32'hAAAA0001;
   localparam logic [31:0] DB = 32'hBBBB0002;
   localparam logic [31:0] DC = 32'hCCCC0003;
   localparam logic [31:0] DD = 32'hDDDD0004;
   localparam logic [31:0] DE = 32'hEEEE0005;
   localparam logic [31:0] DF = 32'hF00D0006;

   logic        clk;
   logic        rst;
   logic [2:0]  cpu_mem_op;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        ld_req;
   logic [13:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic [15:0] ld_count;
   logic        ram_en;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:16383];

   int n_pass;
   int n_total;

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_mem_op (cpu_mem_op),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .ld_req     (ld_req),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_ack     (ld_ack),
      .ld_count   (ld_count),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic        rst;
      logic [2:0]  op;
      logic [31:0] ca;
      logic [31:0] cw;
      logic        lr;
      logic [13:0] la;
      logic [31:0] lw;
      logic        en;
      logic        we;
      logic [13:0] ra;
      logic [31:0] rw;
      logic        st;
      logic        ack;
      logic [31:0] rd;
      logic [15:0] cnt;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   function automatic vec_t v(input logic r, input logic [2:0] op, input logic [31:0] ca,
                              input logic [31:0] cw, input logic lr, input logic [13:0] la,
                              input logic [31:0] lw, input logic en, input logic we,
                              input logic [13:0] ra, input logic [31:0] rw, input logic st,
                              input logic ack, input logic [31:0] rd, input logic [15:0] cnt);
      vec_t t;
      t.rst = r;  t.op = op;  t.ca = ca;  t.cw = cw;
      t.lr = lr;  t.la = la;  t.lw = lw;
      t.en = en;  t.we = we;  t.ra = ra;  t.rw = rw;
      t.st = st;  t.ack = ack; t.rd = rd; t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic r, input logic [2:0] op, input logic [31:0] ca,
                        input logic [31:0] cw, input logic lr, input logic [13:0] la,
                        input logic [31:0] lw);
      @(negedge clk);
      rst = r; cpu_mem_op = op; cpu_addr = ca; cpu_wdata = cw;
      ld_req = lr; ld_addr = la; ld_wdata = lw;
      #1;
   endtask

   int acks;

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b1; cpu_mem_op = NOP; cpu_addr = 0; cpu_wdata = 0;
      ld_req = 1'b0; ld_addr = 0; ld_wdata = 0;

      //            rst op   caddr         cwdata        lr  la  lwdata        en we ra  rwdata        st ack rdata         cnt
      vecs[0]  = v(1, SW,  32'h10,       32'hDEADBEEF, 1, 14'd1, 32'h5,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[1]  = v(1, NOP, 32'h0,        32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[2]  = v(0, SW,  32'h10,       32'hDEADBEEF, 0, 14'd0, 32'h0,      1, 1, 4,  32'hDEADBEEF, 0, 0, 32'h0,        0);
      vecs[3]  = v(0, LW,  32'h10,       32'h0,        0, 14'd0, 32'h0,      1, 0, 4,  32'h0,        1, 0, 32'h0,        0);
      vecs[4]  = v(0, LW,  32'h10,       32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'hDEADBEEF, 0);
      vecs[5]  = v(0, NOP, 32'h0,        32'h0,        1, 14'd5, 32'h11111111, 1, 1, 5, 32'h11111111, 0, 1, 32'h0,       0);
      vecs[6]  = v(0, NOP, 32'h0,        32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        1);
      vecs[7]  = v(1, NOP, 32'h0,        32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[8]  = v(0, SW,  32'h20,       DA,           1, 14'd8, DB,         1, 1, 8,  DB,           1, 1, 32'h0,        0);
      vecs[9]  = v(0, SW,  32'h20,       DA,           1, 14'd9, DC,         1, 1, 8,  DA,           0, 0, 32'h0,        1);
      vecs[10] = v(0, SW,  32'h30,       DD,           1, 14'd9, DC,         1, 1, 9,  DC,           1, 1, 32'h0,        1);
      vecs[11] = v(0, SW,  32'h30,       DD,           0, 14'd0, 32'h0,      1, 1, 12, DD,           0, 0, 32'h0,        2);
      vecs[12] = v(0, LW,  32'h20,       32'h0,        0, 14'd0, 32'h0,      1, 0, 8,  32'h0,        1, 0, 32'h0,        2);
      vecs[13] = v(0, LW,  32'h20,       32'h0,        1, 14'd3, DE,         0, 0, 0,  32'h0,        0, 0, DA,           2);
      vecs[14] = v(0, NOP, 32'h0,        32'h0,        1, 14'd3, DE,         1, 1, 3,  DE,           0, 1, 32'h0,        2);
      vecs[15] = v(0, NOP, 32'h0,        32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        3);
      vecs[16] = v(0, LW,  32'h10,       32'h0,        0, 14'd0, 32'h0,      1, 0, 4,  32'h0,        1, 0, 32'h0,        3);
      vecs[17] = v(1, LW,  32'h10,       32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[18] = v(0, NOP, 32'h0,        32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[19] = v(0, SW,  32'hFFFF0040, DF,           0, 14'd0, 32'h0,      1, 1, 16, DF,           0, 0, 32'h0,        0);
      vecs[20] = v(0, 3'd7, 32'h50,      32'h12345678, 0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, 32'h0,        0);
      vecs[21] = v(0, LW,  32'h40,       32'h0,        1, 14'd7, 32'h77,     1, 1, 7,  32'h77,       1, 1, 32'h0,        0);
      vecs[22] = v(0, LW,  32'h40,       32'h0,        0, 14'd0, 32'h0,      1, 0, 16, 32'h0,        1, 0, 32'h0,        1);
      vecs[23] = v(0, LW,  32'h40,       32'h0,        0, 14'd0, 32'h0,      0, 0, 0,  32'h0,        0, 0, DF,           1);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].op, vecs[i].ca, vecs[i].cw, vecs[i].lr, vecs[i].la, vecs[i].lw);
         chk($sformatf("v%0d ram_en", i),    {31'h0, ram_en},    {31'h0, vecs[i].en});
         chk($sformatf("v%0d ram_we", i),    {31'h0, ram_we},    {31'h0, vecs[i].we});
         chk($sformatf("v%0d ram_addr", i),  {18'h0, ram_addr},  {18'h0, vecs[i].ra});
         chk($sformatf("v%0d ram_wdata", i), ram_wdata,          vecs[i].rw);
         chk($sformatf("v%0d cpu_stall", i), {31'h0, cpu_stall}, {31'h0, vecs[i].st});
         chk($sformatf("v%0d ld_ack", i),    {31'h0, ld_ack},    {31'h0, vecs[i].ack});
         chk($sformatf("v%0d cpu_rdata", i), cpu_rdata,          vecs[i].rd);
         chk($sformatf("v%0d ld_count", i),  {16'h0, ld_count},  {16'h0, vecs[i].cnt});
      end

      // Saturation: reset, then 65540 back-to-back loader writes.
      drive(1, NOP, 0, 0, 0, 0, 0);
      acks = 0;
      for (int i = 0; i < 65540; i++) begin
         drive(0, NOP, 0, 0, 1, i[13:0], i);
         if (ld_ack) acks++;
         if (i == 65535) chk("sat_count_at_65535", {16'h0, ld_count}, 32'h0000FFFF);
      end
      chk("sat_ack_total", acks, 65540);
      drive(0, NOP, 0, 0, 0, 0, 0);
      chk("sat_count_final", {16'h0, ld_count}, 32'h0000FFFF);
      chk("sat_idle_ack", {31'h0, ld_ack}, 32'h0);
      drive(0, NOP, 0, 0, 0, 0, 0);
      chk("sat_count_hold", {16'h0, ld_count}, 32'h0000FFFF);
      drive(1, NOP, 0, 0, 0, 0, 0);
      chk("sat_count_reset", {16'h0, ld_count}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  reset rst, synchronous, active-high.
REQ-003 cpu_mem_op  input  3  CPU data request using the shared MEM op codes (MEM_NOP_OP, MEM_LW_OP, MEM_SW_OP); any other code is treated as NOP.
REQ-004 cpu_addr  input  32  CPU byte address; bits [15:2] select the word, other bits ignored.
REQ-005 cpu_wdata  input  32  CPU store data.
REQ-006 cpu_rdata  output  32  CPU load data.
REQ-007 cpu_stall  output  1  freezes the CPU pipeline while high.
REQ-008 ld_req  input  1  loader write request (loader is write-only).
REQ-009 ld_addr  input  14  loader word address.
REQ-010 ld_wdata  input  32  loader write data.
REQ-011 ld_ack  output  1  one-cycle pulse: loader write performed.
REQ-012 ld_count  output  16  number of accepted loader writes.
REQ-013 ram_en, ram_we  output  1 each  single-port RAM enable and write enable.
REQ-014 ram_addr  output  14  RAM word address.
REQ-015 ram_wdata  output  32  RAM write data.
REQ-016 ram_rdata  input  32  RAM read data, valid one cycle after a read-enabled edge.

Function
REQ-017 States SHALL be IDLE and RD_WAIT only; the arbiter grants at most one RAM access per cycle.
REQ-018 In IDLE, a pending request is any CPU LW/SW op or ld_req=1.
REQ-019 With one pending requester, that requester is granted in the same cycle.
REQ-020 With both pending, the grant goes to the requester not granted most recently (1-bit last_grant register, reset value CPU, so the loader wins the first tie).
REQ-021 CPU SW grant: ram_en=1, ram_we=1, ram_addr=cpu_addr[15:2], ram_wdata=cpu_wdata, cpu_stall=0; state remains IDLE.
REQ-022 CPU LW grant: ram_en=1, ram_we=0, ram_addr=cpu_addr[15:2], cpu_stall=1; next state RD_WAIT.
REQ-023 RD_WAIT: cpu_rdata=ram_rdata, cpu_stall=0, no RAM access; next state IDLE; loader requests wait. A CPU LW therefore takes 2 cycles with 1 stall cycle.
REQ-024 Loader grant: ram_en=1, ram_we=1, ram_addr=ld_addr, ram_wdata=ld_wdata, ld_ack=1 in the same cycle; ld_count increments at the next edge, saturating at 16'hFFFF.
REQ-025 A CPU LW/SW that is pending but not granted SHALL see cpu_stall=1 that cycle.
REQ-026 The CPU holds cpu_mem_op/addr/wdata stable while cpu_stall=1, and the loader holds ld_req/addr/wdata until ld_ack; the arbiter does not latch request fields.
REQ-027 cpu_rdata SHALL be 32'h0 outside RD_WAIT.
REQ-028 With no grant, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-029 A CPU SW and a loader write to the same address in one cycle SHALL be serialized by REQ-020; the later grant's data persists.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, last_grant=CPU, ld_count=0.
REQ-031 While rst=1, all outputs SHALL be 0, including cpu_stall and ld_ack; a read in RD_WAIT is abandoned and no data is delivered.
REQ-032 The first grant after rst deasserts may occur in the first cycle with rst=0.

Verification
REQ-033 CPU SW addr 0x10, data 0xDEADBEEF, loader idle -> same cycle ram_we=1, ram_addr=4, cpu_stall=0.
REQ-034 CPU LW addr 0x10 after REQ-033 -> cycle 1: cpu_stall=1, ram_en=1; cycle 2: cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-035 CPU SW and ld_req both pending for 3 cycles after reset -> loader granted first (ld_ack=1, cpu_stall=1), then CPU, then loader; ld_count=2 at the end.
REQ-036 ld_req asserted during RD_WAIT -> ld_ack=0 that cycle, ld_ack=1 the next cycle.
REQ-037 rst asserted during RD_WAIT -> next cycle state IDLE, cpu_rdata=0, cpu_stall=0, ld_count=0.
REQ-038 65540 back-to-back loader writes -> ld_count=0xFFFF and holds.
